// File: rtl/tagged_dir_dispatcher.sv
// Fetches tagged directions from the ray-generation FIFO and hands each one to an
// intersection unit chosen round-robin, bounding the rays in flight per unit.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module tagged_dir_dispatcher #(
  parameter int NUM_UNITS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_SIZE        = `TAG_SIZE,
  parameter int DIR_BITS        = 24,
  localparam int ENTRY_W        = TAG_SIZE + DIR_BITS,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int PTR_W          = $clog2(NUM_UNITS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       fifo_ready,
  output logic                       fifo_read,
  input  logic                       fifo_valid,
  input  logic [ENTRY_W-1:0]         fifo_dir,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  output logic [NUM_UNITS-1:0]       unit_valid,
  output logic [ENTRY_W-1:0]         unit_dir,
  input  logic [NUM_UNITS-1:0]       unit_done,
  output logic [NUM_UNITS*CNT_W-1:0] outstanding,
  output logic                       idle,
  output logic                       proto_err
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DISPATCH} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0]   eligible;
  logic [NUM_UNITS-1:0]   cnt_zero;
  logic [NUM_UNITS-1:0]   grant_vec;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       rr_next;
  logic                   grant_found;
  logic                   dispatching;
  logic                   done_err;

  // A done arriving this cycle frees its slot, so a full unit can still be granted.
  always_comb begin
    eligible = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cnt_zero[i] = (cnt[i] == '0);
      eligible[i] = unit_ready[i] &&
                    ((cnt[i] < CNT_W'(MAX_OUTSTANDING)) || unit_done[i]);
    end
  end

  always_comb begin
    int j;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    j           = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      if (!grant_found && eligible[j]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
    rr_next = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign dispatching = (state == DISPATCH) && grant_found;
  assign done_err    = |(unit_done & cnt_zero);
  assign idle        = (state == IDLE) && (&cnt_zero);

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_out
    assign outstanding[g*CNT_W +: CNT_W] = cnt[g];
  end

  // The grant edge also takes the idle decision, so back-to-back rays need no
  // dead cycle and the best-case spacing is three cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      fifo_read  <= 1'b0;
      unit_valid <= '0;
      unit_dir   <= '0;
      proto_err  <= 1'b0;
    end else begin
      fifo_read  <= 1'b0;
      unit_valid <= '0;
      if (done_err) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && fifo_ready) begin
            state     <= FETCH;
            fifo_read <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (fifo_valid) begin
            unit_dir <= fifo_dir;
            state    <= DISPATCH;
          end else begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DISPATCH: begin
          if (grant_found) begin
            unit_valid <= grant_vec;
            rr_ptr     <= rr_next;
            if (enable && fifo_ready) begin
              state     <= FETCH;
              fifo_read <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-unit in-flight counters; they saturate at both ends instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (dispatching && grant_vec[i] && !unit_done[i]) begin
          if (cnt[i] < CNT_W'(MAX_OUTSTANDING)) cnt[i] <= cnt[i] + 1'b1;
        end else if (unit_done[i] && !(dispatching && grant_vec[i])) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule
